// File: rtl/mcp_pkg.sv
// Shared constants and helpers for the multi-slot toggle-handshake crossing.
package mcp_pkg;

  // Flop stages on every toggle bit that crosses between clk_a and clk_b.
  localparam int SYNC_STAGES = 2;

  // Pointer width for an n-entry ring: clog2 with a floor of one bit.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mcp_ring_sync2.sv
// Per-bit multi-flop synchroniser for toggle bits; each bit is an independent
// level that only changes once per handshake, so no bus coherency is needed.
module sync2
  import mcp_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [SYNC_STAGES];

  // Shift each toggle bit through the synchroniser chain of the receiving clock.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_stage[s] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int s = 1; s < SYNC_STAGES; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/mcp_ring.sv
// DEPTH-slot clock-domain crossing from clk_a to clk_b. Each slot owns a
// req/ack toggle pair; only those toggle bits are synchronised. The data
// array is written in clk_a and read in clk_b, but a slot is written only
// while it is empty and read only while it is valid, so its contents are
// stable whenever the other domain looks at it.
//
// Handshakes: on the source side a word moves when asend and aready are both
// high at a clk_a edge; asend without aready is ignored and the producer must
// keep offering the word. On the destination side a word moves when bload and
// bvalid are both high at a clk_b edge; bdata presents it from the next cycle.
module mcp_ring
  import mcp_pkg::*;
#(
  parameter  int DWIDTH = 8,
  parameter  int DEPTH  = 2,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk_a,
  input  logic              rstn_a,
  input  logic              asend,
  input  logic [DWIDTH-1:0] adatain,
  output logic              aready,
  output logic [CW-1:0]     a_count,
  input  logic              clk_b,
  input  logic              rstn_b,
  input  logic              bload,
  output logic              bvalid,
  output logic [DWIDTH-1:0] bdata
);

  localparam int PW = ptr_width(DEPTH);

  // Occupancy count over the a-side full vector.
  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) n = n + {{(CW-1){1'b0}}, v[i]};
    return n;
  endfunction

  // ---------------------------------------------------------------- clk_a side
  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_req;
  logic [PW-1:0]     r_wptr;
  logic [DEPTH-1:0]  w_ack_s;
  logic [DEPTH-1:0]  w_full;
  logic              w_accept;

  // A slot is busy from its req toggle until the matching ack toggle arrives.
  assign w_full   = r_req ^ w_ack_s;
  assign aready   = ~w_full[r_wptr];
  assign w_accept = asend & aready;
  assign a_count  = popcount(w_full);

  // Accept: flip the slot's req bit and advance the write pointer (wraps at DEPTH).
  always_ff @(posedge clk_a or negedge rstn_a) begin
    if (!rstn_a) begin
      r_req  <= '0;
      r_wptr <= '0;
    end else if (w_accept) begin
      r_req[r_wptr] <= ~r_req[r_wptr];
      r_wptr        <= r_wptr + 1'b1;
    end
  end

  // Capture the offered word into the free slot; storage carries no reset.
  always_ff @(posedge clk_a) begin
    if (w_accept) r_mem[r_wptr] <= adatain;
  end

  // ---------------------------------------------------------------- clk_b side
  logic [DEPTH-1:0]  r_ack;
  logic [PW-1:0]     r_rptr;
  logic [DWIDTH-1:0] r_bdata;
  logic [DEPTH-1:0]  w_req_s;
  logic [DEPTH-1:0]  w_valid;
  logic              w_load;

  // A slot holds a word for the consumer while its synchronised req differs from ack.
  assign w_valid = w_req_s ^ r_ack;
  assign bvalid  = w_valid[r_rptr];
  assign w_load  = bload & bvalid;
  assign bdata   = r_bdata;

  // Load: register the slot's word, flip its ack bit and advance the read pointer.
  always_ff @(posedge clk_b or negedge rstn_b) begin
    if (!rstn_b) begin
      r_ack   <= '0;
      r_rptr  <= '0;
      r_bdata <= '0;
    end else if (w_load) begin
      r_bdata       <= r_mem[r_rptr];
      r_ack[r_rptr] <= ~r_ack[r_rptr];
      r_rptr        <= r_rptr + 1'b1;
    end
  end

  // ------------------------------------------------------------ synchronisers
  sync2 #(.WIDTH(DEPTH)) u_req_sync (
    .i_clk  (clk_b),
    .i_rstn (rstn_b),
    .i_d    (r_req),
    .o_q    (w_req_s)
  );

  sync2 #(.WIDTH(DEPTH)) u_ack_sync (
    .i_clk  (clk_a),
    .i_rstn (rstn_a),
    .i_d    (r_ack),
    .o_q    (w_ack_s)
  );

endmodule

// File: tb/tb_mcp_ring.sv
// Bench for mcp_ring: directed fill/drain/reset scenarios plus randomized
// traffic at several clock ratios, checked against an ordered word queue and
// occupancy bounds derived from the accept/load history.
`timescale 1ns/1ps
module tb_mcp_ring;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ------------------------------------------------------ clock / reset block
  logic          clk_a = 1'b0;
  logic          clk_b = 1'b0;
  logic          rstn_a = 1'b0;
  logic          rstn_b = 1'b0;
  logic          asend = 1'b0;
  logic          bload = 1'b0;
  logic [DW-1:0] adatain = '0;
  logic          aready;
  logic          bvalid;
  logic [CW-1:0] a_count;
  logic [DW-1:0] bdata;

  real ha = 5.0;
  real hb = 13.5;
  real b_skew = 1.7;

  always begin
    #(ha);
    clk_a = ~clk_a;
  end

  always begin
    #(hb);
    if (b_skew > 0.0) begin
      #(b_skew);
      b_skew = 0.0;
    end
    clk_b = ~clk_b;
  end

  mcp_ring #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_a   (clk_a),
    .rstn_a  (rstn_a),
    .asend   (asend),
    .adatain (adatain),
    .aready  (aready),
    .a_count (a_count),
    .clk_b   (clk_b),
    .rstn_b  (rstn_b),
    .bload   (bload),
    .bvalid  (bvalid),
    .bdata   (bdata)
  );

  // ------------------------------------------------------ scoreboard state
  int            cmp_n = 0;
  int            err_n = 0;
  logic [DW-1:0] exp_q[$];
  int            acc_done = 0;
  int            loads_flagged = 0;
  int            delivered = 0;
  bit            a_acc_flag = 0;
  bit            b_load_flag = 0;
  bit            same_seen = 0;
  longint        a_prev = 0;
  logic [DW-1:0] last_bdata = '0;
  int            b_edges = 0;

  always @(posedge clk_b) b_edges <= b_edges + 1;

  task automatic check_eq(input string nm, input longint got, input longint exp);
    cmp_n++;
    if (got != exp) begin
      err_n++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic check_le(input string nm, input longint got, input longint lim);
    cmp_n++;
    if (got > lim) begin
      err_n++;
      $display("FAIL %s: got %0d, expected <= %0d (t=%0t)", nm, got, lim, $time);
    end
  endtask

  task automatic check_ge(input string nm, input longint got, input longint lim);
    cmp_n++;
    if (got < lim) begin
      err_n++;
      $display("FAIL %s: got %0d, expected >= %0d (t=%0t)", nm, got, lim, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    cmp_n++;
    err_n++;
    $display("FAIL %s: wait bound expired, expected DUT event (t=%0t)", nm, $time);
  endtask

  // a-side compare: occupancy bounds each cycle, accepted words enter the queue.
  always @(negedge clk_a) begin : a_mon
    longint step;
    if (!rstn_a || !rstn_b) begin
      a_acc_flag = 0;
      a_prev     = 0;
      acc_done   = 0;
      exp_q.delete();
    end else begin
      step = a_acc_flag ? 1 : 0;
      if (a_acc_flag) acc_done++;
      check_le("a_count_max", a_count, DEPTH);
      check_eq("aready_vs_count", aready, (a_count < DEPTH) ? 1 : 0);
      check_ge("a_count_floor", a_count, acc_done - loads_flagged);
      check_le("a_count_step", a_count, a_prev + step);
      if (a_acc_flag && a_count == a_prev) same_seen = 1;
      a_prev     = a_count;
      a_acc_flag = asend && aready;
      if (a_acc_flag) exp_q.push_back(adatain);
    end
  end

  // b-side compare: every load must deliver the oldest outstanding word.
  always @(negedge clk_b) begin : b_mon
    logic [DW-1:0] e;
    if (!rstn_a || !rstn_b) begin
      b_load_flag   = 0;
      last_bdata    = '0;
      loads_flagged = 0;
      delivered     = 0;
    end else begin
      if (b_load_flag) begin
        if (exp_q.size() == 0) begin
          timeout_fail("b_unexpected_word");
        end else begin
          e = exp_q.pop_front();
          check_eq("b_data_order", bdata, e);
          last_bdata = e;
          delivered++;
        end
      end else begin
        check_eq("b_data_hold", bdata, last_bdata);
      end
      if (bvalid) check_ge("b_valid_backed", exp_q.size(), 1);
      b_load_flag = bload && bvalid;
      if (b_load_flag) loads_flagged++;
    end
  end

  // ------------------------------------------------------ driver tasks
  task automatic do_reset(input real new_ha, input real new_hb, input real new_skew);
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    asend  = 1'b0;
    bload  = 1'b0;
    repeat (2) @(posedge clk_a);
    repeat (2) @(posedge clk_b);
    ha     = new_ha;
    hb     = new_hb;
    b_skew = new_skew;
    repeat (4) @(posedge clk_a);
    repeat (4) @(posedge clk_b);
    @(negedge clk_a);
    rstn_a = 1'b1;
    @(negedge clk_b);
    rstn_b = 1'b1;
    repeat (2) @(negedge clk_a);
  endtask

  task automatic wait_bvalid(input string nm);
    int n = 0;
    do begin
      @(negedge clk_b);
      n++;
    end while (!bvalid && n < 10);
    if (!bvalid) timeout_fail(nm);
  endtask

  // Load n words with bload held high; check the literal sequence.
  task automatic drain_check(input string nm, input logic [DW-1:0] first, input int n,
                             input int stride);
    @(posedge clk_b); #1;
    bload = 1'b1;
    @(negedge clk_b);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_b);
      check_eq(nm, bdata, longint'(first) + longint'(i * stride));
    end
    check_eq({nm, "_bvalid_low"}, bvalid, 0);
    @(posedge clk_b); #1;
    bload = 1'b0;
  endtask

  task automatic a_rand(input int n);
    int sent = 0;
    int guard = 0;
    bit acc;
    @(posedge clk_a); #1;
    asend   = ($urandom_range(0, 3) != 0);
    adatain = DW'($urandom_range(0, 255));
    while (sent < n && guard < 400000) begin
      @(negedge clk_a);
      acc = asend && aready;
      if (acc) sent++;
      @(posedge clk_a); #1;
      if (acc || !asend) begin
        if (sent < n) begin
          asend   = ($urandom_range(0, 3) != 0);
          adatain = DW'($urandom_range(0, 255));
        end else begin
          asend = 1'b0;
        end
      end
      guard++;
    end
    asend = 1'b0;
    if (sent < n) timeout_fail("rand_send");
  endtask

  task automatic run_random(input real nha, input real nhb, input real nsk, input int n);
    bit a_done;
    int guard;
    do_reset(nha, nhb, nsk);
    a_done = 0;
    fork
      begin
        a_rand(n);
        a_done = 1;
      end
      begin
        guard = 0;
        while (!(a_done && exp_q.size() == 0) && guard < 400000) begin
          @(posedge clk_b); #1;
          bload = ($urandom_range(0, 3) != 0);
          guard++;
        end
        bload = 1'b0;
        if (guard >= 400000) timeout_fail("rand_drain");
      end
    join
    repeat (4) @(negedge clk_b);
    repeat (8) @(negedge clk_a);
    check_eq("rand_delivered", delivered, n);
    check_eq("rand_queue_empty", exp_q.size(), 0);
    check_eq("rand_a_count_idle", a_count, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------ main sequence
  initial begin : main
    int e0;
    int lat;
    do_reset(5.0, 13.5, 0.0);

    // Idle after reset.
    repeat (20) @(negedge clk_a);
    check_eq("rst_aready", aready, 1);
    check_eq("rst_a_count", a_count, 0);
    @(negedge clk_b);
    check_eq("rst_bvalid", bvalid, 0);
    check_eq("rst_bdata", bdata, 0);

    // Fill four slots back to back, then offer 0x55 into a full ring.
    fork
      begin
        @(posedge clk_a); #1;
        for (int i = 0; i < 4; i++) begin
          asend   = 1'b1;
          adatain = DW'(17 * (i + 1));
          @(posedge clk_a); #1;
        end
        adatain = 8'h55;
        @(posedge clk_a); #1;
        asend = 1'b0;
      end
      begin
        repeat (2) @(posedge clk_a);
        e0 = b_edges;
        wait_bvalid("first_valid");
        lat = b_edges - e0;
        check_ge("first_valid_lat_min", lat, 2);
        check_le("first_valid_lat_max", lat, 3);
      end
    join
    @(negedge clk_a);
    check_eq("full_a_count", a_count, 4);
    check_eq("full_aready", aready, 0);
    repeat (6) @(negedge clk_b);
    @(negedge clk_a);
    check_eq("full_hold_a_count", a_count, 4);
    check_eq("full_model_words", exp_q.size(), 4);
    check_eq("full_bvalid", bvalid, 1);

    // Drain with bload held high.
    drain_check("drain_word", 8'h11, 4, 17);
    repeat (8) @(negedge clk_a);
    check_eq("drain_a_count", a_count, 0);
    check_eq("drain_aready", aready, 1);
    @(negedge clk_b);
    check_eq("drain_bdata_hold", bdata, 8'h44);

    // Accept on one slot in the same clk_a cycle that another slot frees.
    @(posedge clk_a); #1;
    asend   = 1'b1;
    adatain = 8'h20;
    @(posedge clk_a); #1;
    asend = 1'b0;
    wait_bvalid("simul_first_valid");
    @(posedge clk_b); #1;
    bload = 1'b1;
    @(posedge clk_b);
    #0.1;
    bload     = 1'b0;
    same_seen = 0;
    asend     = 1'b1;
    adatain   = 8'h21;
    @(posedge clk_a); #1;
    adatain = 8'h22;
    @(posedge clk_a); #1;
    adatain = 8'h23;
    @(posedge clk_a); #1;
    asend = 1'b0;
    @(negedge clk_a);
    check_eq("simul_count_unchanged_seen", same_seen, 1);
    check_eq("simul_a_count", a_count, 3);
    drain_check("simul_word", 8'h21, 3, 1);

    // Joint reset with three words in flight.
    @(posedge clk_a); #1;
    for (int i = 0; i < 3; i++) begin
      asend   = 1'b1;
      adatain = DW'(8'h31 + i);
      @(posedge clk_a); #1;
    end
    asend = 1'b0;
    repeat (2) @(posedge clk_a);
    do_reset(5.0, 13.5, 0.0);
    @(negedge clk_a);
    check_eq("rst2_aready", aready, 1);
    check_eq("rst2_a_count", a_count, 0);
    @(negedge clk_b);
    check_eq("rst2_bvalid", bvalid, 0);
    check_eq("rst2_bdata", bdata, 0);
    @(posedge clk_a); #1;
    asend   = 1'b1;
    adatain = 8'hA5;
    @(posedge clk_a); #1;
    asend = 1'b0;
    wait_bvalid("rst2_valid");
    @(posedge clk_b); #1;
    bload = 1'b1;
    @(posedge clk_b); #1;
    bload = 1'b0;
    @(negedge clk_b);
    check_eq("rst2_word", bdata, 8'hA5);
    repeat (10) begin
      @(negedge clk_b);
      check_eq("rst2_no_extra", bvalid, 0);
    end

    // Randomized traffic at three clock relationships.
    run_random(5.0, 15.0, 2.0, 3334);
    run_random(15.0, 5.0, 2.0, 3334);
    run_random(5.0, 5.0, 3.0, 3334);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule

// File: doc/mcp_ring.md
# mcp_ring

Multi-entry clock-domain-crossing transfer block: a parametrised successor to the single-word toggle-handshake multi-cycle-path synchroniser. The block holds DEPTH slots, so up to DEPTH words can be in flight from the clk_a domain to the clk_b domain, instead of one. Each slot uses its own req/ack toggle pair, and only the toggle bits cross domains. It sits between a clk_a producer and a clk_b consumer wherever a single-word crossing is too slow and a full async FIFO is unwarranted.

## Interface
- DWIDTH, 8: data width in bits, ≥1.
- DEPTH, 2: number of slots; power of two, 2..8.
- CW, $clog2(DEPTH)+1: derived localparam, width of a_count.
- clk_a  in  1  source clock.
- rstn_a  in  1  reset rstn_a, asynchronous, active-low; clock clk_a.
- asend  in  1  source offers adatain this cycle.
- adatain  in  DWIDTH  source data.
- aready  out  1  slot at write pointer is free; transfer occurs on asend & aready.
- a_count  out  CW  occupied slots as seen from clk_a, 0..DEPTH.
- clk_b  in  1  destination clock.
- rstn_b  in  1  destination reset, asynchronous, active-low.
- bload  in  1  consumer takes the word; effective only with bvalid.
- bvalid  out  1  slot at read pointer holds an unconsumed word.
- bdata  out  DWIDTH  registered output word.

## Operation
- clk_a state:
  - mem[DEPTH] is a DWIDTH-wide array with no reset.
  - req[DEPTH] holds toggle bits.
  - wptr is a log2(DEPTH)-bit pointer.
  - ack_s[DEPTH] is ack synchronised into clk_a.
- clk_b state:
  - ack[DEPTH] holds toggle bits.
  - rptr is a log2(DEPTH)-bit pointer.
  - req_s[DEPTH] is req synchronised into clk_b.
- Slot i is full (a-side) when req[i] != ack_s[i]. It is valid (b-side) when req_s[i] != ack[i].
- aready = ~full[wptr], combinational from flops.
- a_count = popcount(full[]), combinational.
- Accept (asend & aready):
  - mem[wptr] <= adatain.
  - req[wptr] toggles.
  - wptr increments, wrapping DEPTH-1→0.
- asend while aready=0 is ignored. No state changes and the data is dropped; the producer must hold the word.
- bvalid = valid[rptr].
- Load (bload & bvalid):
  - bdata <= mem[rptr].
  - ack[rptr] toggles.
  - rptr increments and wraps.
- bload while bvalid=0 leaves bdata and all state unchanged.
- mem[i] is written only while slot i is empty (a-side). It is read only while slot i is valid. Its multi-bit content is therefore stable during the read, and no data bit is synchronised.
- Words are delivered strictly in acceptance order. No loss or duplication occurs under legal use.
- Reset values:
  - aready=1, a_count=0, req=0, ack_s=0, wptr=0.
  - bvalid=0, bdata=0, ack=0, req_s=0, rptr=0.
- Reset rule: rstn_a and rstn_b are asserted together, with overlap of ≥3 cycles of the slower clock. Single-sided reset mid-operation is unsupported. After a joint reset all slots are empty, and in-flight words are discarded.

## Timing
- Accept at clk_a edge k: aready for that slot drops after edge k. When DEPTH > 1, aready stays 1 if the next slot is free, so back-to-back accepts are allowed.
- Forward latency: req toggle to bvalid=1 takes 2 clk_b edges after req_s sampling, i.e. 2–3 clk_b cycles.
- bdata is valid the cycle after the load edge.
- Ack latency: ack toggle to slot free in clk_a takes 2–3 clk_a cycles. a_count decrements in the same cycle aready rises.
- Simultaneous accept on one slot and free of another in the same clk_a cycle: a_count is unchanged.
- Full: a_count=DEPTH and aready=0.
- Sustained throughput with both sides always ready: DEPTH words per round-trip of roughly 4–6 cycles.
- Synchronisers are 2-flop stages on req and ack only, one per slot bit.

## Structure
- Package mcp_pkg holds:
  - SYNC_STAGES=2.
  - A pointer-width function: clog2 with a minimum of 1.
- Sub-module: sync2, one flop pair per bit. It is instantiated as a DEPTH-wide vector twice, once for req→clk_b and once for ack→clk_a.
- The popcount for a_count is a local function and not a sub-module.

## Test plan
- Reset, then idle 20 cycles. Required: aready=1, a_count=0, bvalid=0, bdata=0.
- DEPTH=4, clk_a=100 MHz, clk_b=37 MHz, bload=0. Send 0x11,0x22,0x33,0x44 on consecutive cycles, then a 5th send of 0x55. Required:
  - a_count reaches 4 and aready=0.
  - 0x55 is ignored.
  - bvalid=1 within 3 clk_b cycles of the first send.
- Same fill, then bload=1 continuously. Required:
  - bdata sequence is 0x11,0x22,0x33,0x44, one word per cycle while valid.
  - bvalid=0 afterwards.
  - a_count returns to 0.
  - aready=1.
- Random asend/bload, 10k words, clock ratios 1:3, 3:1 and 1:1 with phase offset. Required: output sequence equals input sequence and a_count ≤ DEPTH always.
- Simultaneous accept and slot-free in one clk_a cycle. Required: a_count is unchanged and wptr advances.
- Joint reset asserted with 3 words in flight. Required: all outputs return to reset values, and a following send of 0xA5 is delivered alone as 0xA5.
